voice_allocator: RTL
====================

# voice_allocator

Sequential note-to-voice scheduler between the MIDI command decoder and the synthesizer voice bank. It takes note-on/note-off requests one at a time and scans all voices for the best target: a held voice with the same note, then an idle voice, then a releasing voice, then a round-robin steal. It then issues a single gate command to that voice. The block owns the `keys_on` vector and reads the per-voice `voice_free` status from the envelope generators.

## Interface
- `VOICES`, 32, number of voices (≥2).
- `VB`, 5, voice index width; `2**VB >= VOICES`.
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  combinational: `(state==IDLE) & ~all_off`.
- `req_on`  in  1  1 = note-on, 0 = note-off.
- `req_note`  in  7  MIDI note number.
- `req_vel`  in  7  velocity; note-on with vel 0 is treated as note-off.
- `all_off`  in  1  single-cycle pulse: release everything, abort any request in flight.
- `voice_free`  in  VOICES  1 = voice envelope fully decayed.
- `keys_on`  out  VOICES  1 = voice gated (key held).
- `out_valid`  out  1  one-cycle command strobe.
- `out_voice`  out  VB  target voice.
- `out_note`  out  7  note for target.
- `out_vel`  out  7  velocity (0 on gate-off).
- `out_gate`  out  1  1 = gate on, 0 = gate off.
- `out_steal`  out  1  1 = command pre-empts a held voice.

## Operation
- **Internal state:**
  - `note_tbl[VOICES]` (7 b each): last note assigned per voice.
  - `steal_ptr` (VB b): round-robin steal pointer.
  - `idx` (VB b): scan index.
  - Latched request fields.
- **FSM states:** IDLE, SCAN, ISSUE.
- **IDLE:**
  - On `req_valid & req_ready`, latch `req_*` and set `idx=0`, go to SCAN.
  - Latch `is_on = req_on & (req_vel!=0)`.
- **SCAN:** one voice per cycle, `idx` 0..VOICES-1. Voice `idx` is examined with the live `voice_free[idx]`, `keys_on[idx]` and `note_tbl[idx]`. The first hit (lowest index) is recorded for each class:
  - M: `keys_on` & `note_tbl==note`.
  - F: `~keys_on` & `voice_free`.
  - R: `~keys_on` & `~voice_free`.
- **Decision, on the edge leaving the last SCAN cycle (loads output registers):**
  - Note-on priority:
    - M: retrigger, gate=1, steal=0.
    - else F: gate=1, steal=0.
    - else R: gate=1, steal=0.
    - else voice `steal_ptr`: gate=1, steal=1. Then `steal_ptr` advances by 1, wrapping VOICES-1 → 0.
  - Note-off:
    - M: gate=0, vel=0.
    - No M: no command (`out_valid` stays 0).
- **ISSUE:**
  - `out_valid` is high for exactly this cycle when a command exists.
  - `keys_on[out_voice]` and `note_tbl[out_voice]` take their new values on the edge entering ISSUE, so they are visible during ISSUE.
  - Next state is IDLE.
- **all_off (any state):**
  - Clears `keys_on` on the next edge and forces IDLE.
  - Drops the latched request; `out_valid` is 0 in the following cycle.
  - `note_tbl` and `steal_ptr` are kept.
  - When `all_off` coincides with `req_valid` in IDLE, `all_off` wins and the request is not accepted.
- **Reset values:** `keys_on=0`, `note_tbl=0`, `steal_ptr=0`, `idx=0`, state IDLE, all `out_*=0`.
- **Reset asserted mid-operation:** immediate return to the reset values; no partial command is emitted.

## Timing
- Accept edge = cycle 0.
- SCAN occupies cycles 1..VOICES.
- ISSUE occurs at cycle VOICES+1; `out_*` are valid there.
- `req_ready` is high again at cycle VOICES+2.
- Throughput: one request per VOICES+2 cycles. Latency does not depend on whether a match exists.
- `out_*` hold their values after ISSUE until the next command. Only `out_valid` is a pulse.
- `voice_free` changes during SCAN affect only voices not yet examined.

## Test plan
- **Reset then note-on:** reset, `voice_free` all 1, note-on 60/100 accepted at cycle 0 → `out_valid` at cycle 33 with voice 0, gate 1, vel 100, steal 0; `keys_on=0x00000001`; `req_ready` high at cycle 34.
- **Second note and retrigger:** note-on 64/90 → voice 1. Then note-on 60/50 → voice 0 retrigger, vel 50; `keys_on` stays `0x00000003`.
- **Note-off, matched and unmatched:** note-off 60 → voice 0, gate 0, vel 0, `keys_on=0x00000002`. Note-on 64 with vel 0 → voice 1 gate-off. Note-off 72 (unmatched) → no `out_valid`; ready at cycle 34.
- **Stealing (VOICES=4):** hold notes 10..13 on voices 0..3, `voice_free=0` → note-on 20 steals voice 0 (steal=1); next note-on 21 steals voice 1; `note_tbl[0]=20`.
- **Releasing preference (VOICES=4):** voices 0,1,3 held, voice 2 `keys_on=0`, `voice_free=0`, note-on 30 → voice 2, steal 0, `steal_ptr` unchanged. With voice 1 also released but `voice_free=1` → voice 1 preferred.
- **all_off:** pulse `all_off` at cycle 5 of a SCAN → `keys_on=0` next cycle, no `out_valid`, `req_ready=1` the cycle after the pulse. Pulse coincident with `req_valid` in IDLE → request not accepted.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Request/command bundle between the MIDI decoder (master) and the voice allocator (slave).
interface voice_allocator_if #(
  parameter int VB = 5
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_on;
  logic [6:0]    req_note;
  logic [6:0]    req_vel;
  logic          out_valid;
  logic [VB-1:0] out_voice;
  logic [6:0]    out_note;
  logic [6:0]    out_vel;
  logic          out_gate;
  logic          out_steal;

  modport master (
    output req_valid, req_on, req_note, req_vel,
    input  req_ready,
    input  out_valid, out_voice, out_note, out_vel, out_gate, out_steal
  );

  modport slave (
    input  req_valid, req_on, req_note, req_vel,
    output req_ready,
    output out_valid, out_voice, out_note, out_vel, out_gate, out_steal
  );
endinterface

// File: rtl/voice_allocator.sv
// Sequential note-to-voice scheduler: scans one voice per cycle, then issues one gate command.
module voice_allocator #(
  parameter int VOICES = 32,
  parameter int VB     = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  voice_allocator_if.slave  bus,
  input  logic              all_off,
  input  logic [VOICES-1:0] voice_free,
  output logic [VOICES-1:0] keys_on
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [VB-1:0] LAST = VB'(VOICES - 1);

  logic [1:0]    state;
  logic [VB-1:0] idx;
  logic [VB-1:0] steal_ptr;
  logic [6:0]    note_tbl [VOICES];
  logic [6:0]    lat_note;
  logic [6:0]    lat_vel;
  logic          lat_on;
  logic          m_hit, f_hit, r_hit;
  logic [VB-1:0] m_idx, f_idx, r_idx;

  logic          cur_m, cur_f, cur_r;
  logic          m_any, f_any, r_any;
  logic [VB-1:0] m_sel, f_sel, r_sel;
  logic          dec_cmd, dec_gate, dec_steal;
  logic [VB-1:0] dec_voice;

  assign bus.req_ready = (state == IDLE) & ~all_off;

  // Classify the voice under examination; the final decision folds in the last voice directly.
  always_comb begin
    cur_m = keys_on[idx] & (note_tbl[idx] == lat_note);
    cur_f = ~keys_on[idx] & voice_free[idx];
    cur_r = ~keys_on[idx] & ~voice_free[idx];
    m_any = m_hit | cur_m;
    f_any = f_hit | cur_f;
    r_any = r_hit | cur_r;
    m_sel = m_hit ? m_idx : idx;
    f_sel = f_hit ? f_idx : idx;
    r_sel = r_hit ? r_idx : idx;

    dec_cmd   = 1'b0;
    dec_gate  = 1'b0;
    dec_steal = 1'b0;
    dec_voice = m_sel;
    if (lat_on) begin
      dec_cmd  = 1'b1;
      dec_gate = 1'b1;
      if (m_any)      dec_voice = m_sel;
      else if (f_any) dec_voice = f_sel;
      else if (r_any) dec_voice = r_sel;
      else begin
        dec_voice = steal_ptr;
        dec_steal = 1'b1;
      end
    end else begin
      dec_cmd = m_any;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      steal_ptr     <= '0;
      keys_on       <= '0;
      lat_note      <= '0;
      lat_vel       <= '0;
      lat_on        <= 1'b0;
      m_hit         <= 1'b0;
      f_hit         <= 1'b0;
      r_hit         <= 1'b0;
      m_idx         <= '0;
      f_idx         <= '0;
      r_idx         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_voice <= '0;
      bus.out_note  <= '0;
      bus.out_vel   <= '0;
      bus.out_gate  <= 1'b0;
      bus.out_steal <= 1'b0;
      for (int i = 0; i < VOICES; i++) note_tbl[i] <= '0;
    end else if (all_off) begin
      // Release everything and drop any request in flight; note memory and steal order survive.
      state         <= IDLE;
      idx           <= '0;
      keys_on       <= '0;
      m_hit         <= 1'b0;
      f_hit         <= 1'b0;
      r_hit         <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          if (bus.req_valid) begin
            lat_note <= bus.req_note;
            lat_vel  <= bus.req_vel;
            lat_on   <= bus.req_on & (bus.req_vel != 7'd0);
            idx      <= '0;
            m_hit    <= 1'b0;
            f_hit    <= 1'b0;
            r_hit    <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (idx == LAST) begin
            state         <= ISSUE;
            idx           <= '0;
            bus.out_valid <= dec_cmd;
            if (dec_cmd) begin
              bus.out_voice       <= dec_voice;
              bus.out_note        <= lat_note;
              bus.out_vel         <= dec_gate ? lat_vel : 7'd0;
              bus.out_gate        <= dec_gate;
              bus.out_steal       <= dec_steal;
              keys_on[dec_voice]  <= dec_gate;
              note_tbl[dec_voice] <= lat_note;
            end
            if (dec_steal) steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
          end else begin
            if (cur_m && !m_hit) begin
              m_hit <= 1'b1;
              m_idx <= idx;
            end
            if (cur_f && !f_hit) begin
              f_hit <= 1'b1;
              f_idx <= idx;
            end
            if (cur_r && !r_hit) begin
              r_hit <= 1'b1;
              r_idx <= idx;
            end
            idx <= idx + 1'b1;
          end
        end
        ISSUE: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
